// File: rtl/transmission8_sched_if.sv
// Bus bundle for the eight-channel serial transmit scheduler.
// master = requester side, slave = scheduler side.
interface transmission8_sched_if;
    logic [7:0]  req;
    logic [63:0] req_data;
    logic [7:0]  ack;
    logic        A;
    logic        B;
    logic        C;
    logic [7:0]  tx;
    logic        busy;

    modport master (
        output req, req_data,
        input  ack, A, B, C, tx, busy
    );

    modport slave (
        input  req, req_data,
        output ack, A, B, C, tx, busy
    );
endinterface

// File: rtl/transmission8_sched.sv
// Round-robin scheduler sharing one UART-style serializer over eight lines.
// Define TRANSMISSION8_SCHED_PARITY_EN to add an even-parity bit after data.
module transmission8_sched #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    transmission8_sched_if.slave bus
);

`ifdef TRANSMISSION8_SCHED_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    localparam logic [7:0] CNT_MAX = 8'(BIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  last_q, last_d;
    logic [7:0]  ack_q, ack_d;
`ifdef TRANSMISSION8_SCHED_PARITY_EN
    logic        par_q, par_d;
`endif

    logic        found;
    logic [2:0]  pick;
    logic [2:0]  cand;
    logic        bit_end;
    logic        line_bit;
    logic [7:0]  tx_c;
    logic [7:0]  cap_byte;

    // Search starts just after the last winner and wraps back onto it.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int i = 1; i <= 8; i++) begin
            cand = last_q + 3'(i);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign cap_byte = bus.req_data[{pick, 3'b000} +: 8];
    assign bit_end  = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? 8'd0 : cnt_q + 8'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        grant_d = grant_q;
        last_d  = last_q;
        ack_d   = 8'd0;
`ifdef TRANSMISSION8_SCHED_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                idx_d = 3'd0;
                if (found) begin
                    state_d = START;
                    shreg_d = cap_byte;
                    grant_d = pick;
                    last_d  = pick;
                    ack_d   = 8'd1 << pick;
`ifdef TRANSMISSION8_SCHED_PARITY_EN
                    par_d   = ^cap_byte;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef TRANSMISSION8_SCHED_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef TRANSMISSION8_SCHED_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            grant_q <= 3'd0;
            last_q  <= 3'd7;
            ack_q   <= 8'd0;
`ifdef TRANSMISSION8_SCHED_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
`ifdef TRANSMISSION8_SCHED_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        line_bit = 1'b1;
        unique case (state_q)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shreg_q[0];
`ifdef TRANSMISSION8_SCHED_PARITY_EN
            PARITY:  line_bit = par_q;
`endif
            default: line_bit = 1'b1;
        endcase
        tx_c          = 8'hFF;
        tx_c[grant_q] = line_bit;
    end

    assign bus.tx   = tx_c;
    assign bus.ack  = ack_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.A    = grant_q[2];
    assign bus.B    = grant_q[1];
    assign bus.C    = grant_q[0];

endmodule

// File: doc/transmission8_sched.md
TRANSMISSION8_SCHED -- requirements
Module: transmission8_sched

Interface
REQ-001 Parameter: BIT_CYCLES, default 4, clocks per serial bit (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  per-channel transmit request, level, held until matching ack.
REQ-005 req_data  input  64  channel i byte at bits [8i+7:8i], stable while req[i] high.
REQ-006 ack  output  8  one-hot, one-cycle pulse when channel byte is captured.
REQ-007 A, B, C  output  1 each  granted channel select, {A,B,C} = channel number, A = MSB.
REQ-008 tx  output  8  per-channel serial lines, idle high.
REQ-009 busy  output  1  high while a frame is in progress.

Function
REQ-010 The block SHALL share eight serial lines through one serializer, one frame at a time.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP (PARITY when enabled).
- IDLE: any req high -> capture byte, load grant, pulse ack, enter START.
- START -> DATA -> (PARITY) -> STOP -> IDLE.
- Each state lasts BIT_CYCLES cycles except IDLE; DATA lasts 8*BIT_CYCLES.
REQ-012 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod 8, ascending, wrapping 7->0; first set req wins.
REQ-013 Capture edge: ack[g], {A,B,C}=g, busy=1 and tx[g]=0 (start bit) SHALL all appear in the cycle after the capture edge.
REQ-014 Frame on tx[g]: start bit 0, data bits LSB first, stop bit 1; each bit held exactly BIT_CYCLES cycles.
REQ-015 Non-granted tx lines SHALL stay 1 at all times; tx[g] SHALL be 1 whenever busy=0.
REQ-016 {A,B,C} SHALL hold the last granted channel while idle.
REQ-017 After STOP the FSM SHALL spend exactly one cycle in IDLE (busy=0) before the next capture.
REQ-018 The byte SHALL be captured into an internal shift register; req_data changes after ack SHALL not affect the frame.
REQ-019 A req dropped before capture SHALL produce no ack and no frame.
REQ-020 req changes during a frame SHALL be ignored until IDLE.
REQ-021 Bit counter SHALL count 0..BIT_CYCLES-1 and wrap; bit index 0..7 in DATA.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, tx=8'hFF, ack=0, busy=0, {A,B,C}=000, and last_granted=7 (so channel 0 has first priority).
REQ-023 Reset asserted mid-frame SHALL abort the frame; no ack is reissued; requester re-arbitrates after release.
REQ-024 First capture SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro TRANSMISSION8_SCHED_PARITY_EN defined: a PARITY state of BIT_CYCLES cycles SHALL follow DATA, transmitting even parity (XOR of the 8 data bits); frame = 11 bits.
REQ-026 Macro undefined: no PARITY state, no parity logic; frame = 10 bits.

Verification (BIT_CYCLES=4, parity off unless stated)
REQ-027 req=8'h08, byte3=8'hA5 -> ack=8'h08 for 1 cycle, ABC=011, tx[3] = 0,1,0,1,0,0,1,0,1,1 each 4 cycles, busy high 40 cycles, other tx high.
REQ-028 req=8'hFF held after reset, every ack followed by a new request -> grant order 0,1,2,...,7,0, with one idle cycle between frames.
REQ-029 req=8'h24 held, last_granted=5 -> channel 2 granted next (wrap), then 5.
REQ-030 rst_n low at cycle 15 of a channel-6 frame -> tx=8'hFF and busy=0 immediately; after release with req[6] still high -> fresh frame from start bit.
REQ-031 Parity on, channel 1 byte 8'h07 -> parity bit 1, stop after 40 cycles, busy high 44 cycles.
REQ-032 req[4] pulsed and dropped during a channel-0 frame -> no ack[4], no activity on tx[4].
